// File: rtl/pop_panel_pkg.sv
// Shared constants and channel state type for the front-panel button conditioner.
package pop_panel_pkg;

   localparam int DEF_N_BUTTONS           = 6;
   localparam int DEF_TICK_DIV            = 250;
   localparam int DEF_DEBOUNCE_TICKS      = 200;
   localparam int DEF_REPEAT_DELAY_TICKS  = 5000;
   localparam int DEF_REPEAT_PERIOD_TICKS = 1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } chan_state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: tick-based debounce of the synchronised level, then the
// press/hold/repeat state machine with registered level and strobes.
module button_channel
   import pop_panel_pkg::*;
#(
   parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
   parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_tick,
   input  logic i_sync_n,
   input  logic i_repeat_en,
   output logic o_pressed,
   output logic o_press_pulse,
   output logic o_release_pulse
);

   localparam int DB_W = cnt_width(DEBOUNCE_TICKS - 1);
   localparam int RC_W = cnt_width(REPEAT_DELAY_TICKS);

   logic              r_stable;
   logic [DB_W-1:0]   r_dcnt;
   chan_state_e       r_state;
   chan_state_e       w_state_nxt;
   logic [RC_W-1:0]   r_rcnt;
   logic [RC_W-1:0]   w_rcnt_nxt;
   logic [RC_W-1:0]   w_interval;
   logic              r_press_pulse;
   logic              r_release_pulse;
   logic              w_press_pulse;
   logic              w_release_pulse;
   logic              w_mismatch;
   logic              w_accept;
   logic              w_rise;
   logic              w_fall;
   logic              w_expire;

   assign w_mismatch = (~i_sync_n) != r_stable;
   assign w_accept   = w_mismatch && i_tick && (r_dcnt == DB_W'(DEBOUNCE_TICKS - 1));
   assign w_rise     = w_accept && !r_stable;
   assign w_fall     = w_accept && r_stable;

   assign w_interval = (r_state == REPEAT) ? RC_W'(REPEAT_PERIOD_TICKS - 1)
                                           : RC_W'(REPEAT_DELAY_TICKS - 1);
   assign w_expire   = i_tick && i_repeat_en && (r_rcnt == w_interval);

   // Any cycle in agreement discards the partial count, so short glitches vanish.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stable <= 1'b0;
         r_dcnt   <= '0;
      end else if (!w_mismatch) begin
         r_dcnt   <= '0;
      end else if (w_accept) begin
         r_stable <= ~r_stable;
         r_dcnt   <= '0;
      end else if (i_tick) begin
         r_dcnt   <= r_dcnt + DB_W'(1);
      end else begin
         r_dcnt   <= r_dcnt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rcnt_nxt      = r_rcnt;
      w_press_pulse   = 1'b0;
      w_release_pulse = 1'b0;
      case (r_state)
         IDLE: begin
            w_rcnt_nxt = '0;
            if (w_rise) begin
               w_state_nxt   = HELD;
               w_press_pulse = 1'b1;
            end else begin
               w_state_nxt   = IDLE;
            end
         end
         HELD, REPEAT: begin
            // Release wins over a repeat expiring on the same tick.
            if (w_fall) begin
               w_state_nxt     = IDLE;
               w_release_pulse = 1'b1;
               w_rcnt_nxt      = '0;
            end else if (!i_repeat_en) begin
               w_rcnt_nxt      = '0;
            end else if (w_expire) begin
               w_state_nxt     = REPEAT;
               w_press_pulse   = 1'b1;
               w_rcnt_nxt      = '0;
            end else if (i_tick) begin
               w_rcnt_nxt      = r_rcnt + RC_W'(1);
            end else begin
               w_rcnt_nxt      = r_rcnt;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_rcnt          <= '0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_rcnt          <= w_rcnt_nxt;
         r_press_pulse   <= w_press_pulse;
         r_release_pulse <= w_release_pulse;
      end
   end

   assign o_pressed       = r_stable;
   assign o_press_pulse   = r_press_pulse;
   assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: pin synchronisers, shared debounce tick
// prescaler and one debounce/repeat channel per button.
module button_conditioner
   import pop_panel_pkg::*;
#(
   parameter int N_BUTTONS           = DEF_N_BUTTONS,
   parameter int TICK_DIV            = DEF_TICK_DIV,
   parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
   parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
   input  logic                 clk_2M5,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] buttons_n,
   input  logic [N_BUTTONS-1:0] repeat_en,
   output logic [N_BUTTONS-1:0] pressed,
   output logic [N_BUTTONS-1:0] press_pulse,
   output logic [N_BUTTONS-1:0] release_pulse
);

   localparam int DIV_W = cnt_width(TICK_DIV - 1);

   logic [N_BUTTONS-1:0] r_sync_meta;
   logic [N_BUTTONS-1:0] r_sync_n;
   logic [DIV_W-1:0]     r_div;
   logic                 w_tick;

   // Reset to the released level so a held button is re-debounced afterwards.
   always_ff @(posedge clk_2M5) begin
      if (reset) begin
         r_sync_meta <= '1;
         r_sync_n    <= '1;
      end else begin
         r_sync_meta <= buttons_n;
         r_sync_n    <= r_sync_meta;
      end
   end

   assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

   always_ff @(posedge clk_2M5) begin
      if (reset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      button_channel #(
         .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
         .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
         .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
      ) u_chan (
         .i_clk           (clk_2M5),
         .i_reset         (reset),
         .i_tick          (w_tick),
         .i_sync_n        (r_sync_n[gi]),
         .i_repeat_en     (repeat_en[gi]),
         .o_pressed       (pressed[gi]),
         .o_press_pulse   (press_pulse[gi]),
         .o_release_pulse (release_pulse[gi])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: cycle-level behavioural model
// plus literal strobe timings for the small-parameter scenarios.
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int N    = 6;
   localparam int TDIV = 4;
   localparam int DB   = 3;
   localparam int RDLY = 10;
   localparam int RPER = 4;

   logic         clk_2M5 = 1'b0;
   logic         reset   = 1'b1;
   logic [N-1:0] buttons_n = '1;
   logic [N-1:0] repeat_en = '0;
   logic [N-1:0] pressed;
   logic [N-1:0] press_pulse;
   logic [N-1:0] release_pulse;

   button_conditioner #(
      .N_BUTTONS           (N),
      .TICK_DIV            (TDIV),
      .DEBOUNCE_TICKS      (DB),
      .REPEAT_DELAY_TICKS  (RDLY),
      .REPEAT_PERIOD_TICKS (RPER)
   ) dut (
      .clk_2M5       (clk_2M5),
      .reset         (reset),
      .buttons_n     (buttons_n),
      .repeat_en     (repeat_en),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #200 clk_2M5 = ~clk_2M5;

   int total = 0;
   int bad   = 0;
   int cnum  = 0;
   bit started = 1'b0;

   // Model: what each channel must show, derived from elapsed ticks.
   int           m_cyc;
   logic [N-1:0] m_s1, m_s2;
   bit           m_stable [N];
   int           m_mis    [N];
   int           m_hold   [N];
   bit           m_first  [N];
   logic [N-1:0] m_pressed, m_pp, m_rp;
   bit           m_tick;
   bit           m_acc;

   int pp0_q[$], rp0_q[$], pp2_q[$], pp3_q[$], rp2_q[$], rp3_q[$], pp4_q[$], rp4_q[$];
   int ch1_evt;
   int exp_q[$];

   always @(posedge clk_2M5) begin
      started = 1'b1;
      if (reset) begin
         m_cyc = 0;
         cnum  = 0;
         m_s1  = '1;
         m_s2  = '1;
         m_pressed = '0;
         m_pp = '0;
         m_rp = '0;
         for (int c = 0; c < N; c++) begin
            m_stable[c] = 1'b0;
            m_mis[c]    = 0;
            m_hold[c]   = 0;
            m_first[c]  = 1'b1;
         end
      end else begin
         m_tick = ((m_cyc % TDIV) == TDIV - 1);
         m_cyc++;
         cnum++;
         for (int c = 0; c < N; c++) begin
            m_pp[c] = 1'b0;
            m_rp[c] = 1'b0;
            m_acc   = 1'b0;
            if ((!m_s2[c]) == m_stable[c]) begin
               m_mis[c] = 0;
            end else if (m_tick) begin
               m_mis[c]++;
               if (m_mis[c] == DB) begin
                  m_acc       = 1'b1;
                  m_mis[c]    = 0;
                  m_stable[c] = !m_stable[c];
                  m_hold[c]   = 0;
                  m_first[c]  = 1'b1;
                  if (m_stable[c]) m_pp[c] = 1'b1;
                  else             m_rp[c] = 1'b1;
               end
            end
            if (!m_acc && m_stable[c]) begin
               if (!repeat_en[c]) begin
                  m_hold[c] = 0;
               end else if (m_tick) begin
                  m_hold[c]++;
                  if (m_hold[c] == (m_first[c] ? RDLY : RPER)) begin
                     m_pp[c]    = 1'b1;
                     m_hold[c]  = 0;
                     m_first[c] = 1'b0;
                  end
               end
            end
            m_pressed[c] = m_stable[c];
         end
         m_s2 = m_s1;
         m_s1 = buttons_n;
      end
   end

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%b want=%b", nm, cnum, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic check_log(input string nm, input int act[$], input int exp[$]);
      check_int({nm, "_count"}, act.size(), exp.size());
      for (int i = 0; i < act.size() && i < exp.size(); i++) begin
         check_int($sformatf("%s_cycle%0d", nm, i), act[i], exp[i]);
      end
   endtask

   always @(negedge clk_2M5) begin
      if (started) begin
         chk("pressed", pressed, m_pressed);
         chk("press_pulse", press_pulse, m_pp);
         chk("release_pulse", release_pulse, m_rp);
         if (press_pulse[0])   pp0_q.push_back(cnum);
         if (release_pulse[0]) rp0_q.push_back(cnum);
         if (press_pulse[1] || release_pulse[1] || pressed[1]) ch1_evt++;
         if (press_pulse[2])   pp2_q.push_back(cnum);
         if (press_pulse[3])   pp3_q.push_back(cnum);
         if (release_pulse[2]) rp2_q.push_back(cnum);
         if (release_pulse[3]) rp3_q.push_back(cnum);
         if (press_pulse[4])   pp4_q.push_back(cnum);
         if (release_pulse[4]) rp4_q.push_back(cnum);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_2M5);
      #1;
   endtask

   // Returns in cycle 0: the next edge is the first with reset low.
   task automatic do_reset();
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
   endtask

   task automatic clear_logs();
      pp0_q.delete(); rp0_q.delete(); pp2_q.delete(); pp3_q.delete();
      rp2_q.delete(); rp3_q.delete(); pp4_q.delete(); rp4_q.delete();
      ch1_evt = 0;
   endtask

   initial begin
      // Held before reset, no repeat: one press at 12, nothing more.
      buttons_n = 6'b111110;
      repeat_en = 6'b000000;
      do_reset();
      clear_logs();
      wait_cyc(80);
      exp_q = {12};
      check_log("A_press0", pp0_q, exp_q);
      exp_q = {};
      check_log("A_release0", rp0_q, exp_q);

      // Repeat enabled; release lands so its expiry tick coincides with a repeat.
      repeat_en = 6'b000001;
      do_reset();
      clear_logs();
      wait_cyc(102);
      buttons_n[0] = 1'b1;
      wait_cyc(40);
      exp_q = {12, 52, 68, 84, 100};
      check_log("B_press0", pp0_q, exp_q);
      exp_q = {116};
      check_log("B_release0", rp0_q, exp_q);

      // Short glitches on channel 1, then channels 2 and 3 together.
      buttons_n = '1;
      repeat_en = '0;
      do_reset();
      clear_logs();
      wait_cyc(20);
      for (int r = 0; r < 4; r++) begin
         buttons_n[1] = 1'b0;
         wait_cyc(6);
         buttons_n[1] = 1'b1;
         wait_cyc(10);
      end
      buttons_n[3:2] = 2'b00;
      wait_cyc(25);
      buttons_n[3:2] = 2'b11;
      wait_cyc(25);
      check_int("C_ch1_activity", ch1_evt, 0);
      exp_q = {96};
      check_log("D_press2", pp2_q, exp_q);
      check_log("D_press3", pp3_q, exp_q);
      exp_q = {120};
      check_log("D_release2", rp2_q, exp_q);
      check_log("D_release3", rp3_q, exp_q);

      // Reset while channel 4 repeats, button still held afterwards.
      buttons_n = 6'b101111;
      repeat_en = 6'b010000;
      do_reset();
      clear_logs();
      wait_cyc(60);
      reset = 1'b1;
      wait_cyc(1);
      check_int("E_pressed_after_reset", int'(pressed), 0);
      check_int("E_press_pulse_after_reset", int'(press_pulse), 0);
      check_int("E_release_pulse_after_reset", int'(release_pulse), 0);
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(30);
      exp_q = {12, 52, 12};
      check_log("E_press4", pp4_q, exp_q);
      exp_q = {};
      check_log("E_release4", rp4_q, exp_q);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
